// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      DONE
   } state_t;

   localparam logic OWN_I = 1'b0;
   localparam logic OWN_D = 1'b1;

   localparam int unsigned DEF_ADDR_W = 6;
   localparam int unsigned DEF_DATA_W = 32;

   // Wide enough for the largest legal MAX_WAIT (15).
   localparam int unsigned WAIT_CNT_W = 4;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and memory-side signals of the data-memory arbiter.
interface dmem_arbiter_if #(
   parameter int unsigned ADDR_W = 6,
   parameter int unsigned DATA_W = 32
);

   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic              i_ack;
   logic [DATA_W-1:0] i_rdata;

   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_ack;
   logic [DATA_W-1:0] d_rdata;

   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   logic              busy;

   // Arbiter side.
   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      output i_ack, i_rdata, d_ack, d_rdata,
      output mem_read, mem_write, mem_addr, mem_wdata, busy
   );

   // Pipeline and memory side.
   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      input  i_ack, i_rdata, d_ack, d_rdata,
      input  mem_read, mem_write, mem_addr, mem_wdata, busy
   );

endinterface

// File: rtl/dmem_arbiter_wait_counter.sv
// Saturating count of arbitrations lost by the instruction port.
module arb_wait_counter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic inc_i,
   input  logic clr_i,
   output logic sat_o
);

   localparam logic [WAIT_CNT_W-1:0] MAX_C = WAIT_CNT_W'(MAX_WAIT);

   logic [WAIT_CNT_W-1:0] cnt_q;
   logic [WAIT_CNT_W-1:0] cnt_d;

   // Clear wins over increment; increment stops at MAX_WAIT.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != MAX_C)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign sat_o = (cnt_q == MAX_C);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for a single-ported data memory: D has fixed
// priority, I is forced through after MAX_WAIT consecutive losses.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W   = DEF_ADDR_W,
   parameter int unsigned DATA_W   = DEF_DATA_W,
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic           clk,
   input  logic           rst,
   dmem_arbiter_if.slave  bus
);

   state_t            state_q,   state_d;
   logic              owner_q,   owner_d;
   logic              we_q,      we_d;
   logic [ADDR_W-1:0] addr_q,    addr_d;
   logic [DATA_W-1:0] wdata_q,   wdata_d;
   logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

   logic cnt_inc;
   logic cnt_clr;
   logic cnt_sat;

   arb_wait_counter #(
      .MAX_WAIT (MAX_WAIT)
   ) u_wait (
      .clk   (clk),
      .rst   (rst),
      .inc_i (cnt_inc),
      .clr_i (cnt_clr),
      .sat_o (cnt_sat)
   );

   // Next state: arbitrate and latch the request in IDLE, capture read data
   // at the end of ACCESS, ack in DONE.
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      i_rdata_d = i_rdata_q;
      d_rdata_d = d_rdata_q;
      cnt_inc   = 1'b0;
      cnt_clr   = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.i_req || bus.d_req) begin
               if (bus.d_req && !(bus.i_req && cnt_sat)) begin
                  owner_d = OWN_D;
                  we_d    = bus.d_we;
                  addr_d  = bus.d_addr;
                  wdata_d = bus.d_wdata;
                  cnt_inc = bus.i_req;
               end else begin
                  owner_d = OWN_I;
                  we_d    = 1'b0;
                  addr_d  = bus.i_addr;
                  wdata_d = '0;
                  cnt_clr = 1'b1;
               end
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            if (owner_q == OWN_I) begin
               i_rdata_d = bus.mem_rdata;
            end else begin
               d_rdata_d = we_q ? '0 : bus.mem_rdata;
            end
            state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and latched-request registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         owner_q   <= OWN_D;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
      end
   end

   // Memory strobes only in ACCESS; rst gates the write so an access
   // abandoned by reset never reaches the array.
   assign bus.mem_read  = (state_q == ACCESS) && !we_q;
   assign bus.mem_write = (state_q == ACCESS) && we_q && !rst;
   assign bus.mem_addr  = (state_q == ACCESS) ? addr_q  : '0;
   assign bus.mem_wdata = (state_q == ACCESS) ? wdata_q : '0;

   assign bus.i_ack   = (state_q == DONE) && (owner_q == OWN_I);
   assign bus.d_ack   = (state_q == DONE) && (owner_q == OWN_D);
   assign bus.i_rdata = i_rdata_q;
   assign bus.d_rdata = d_rdata_q;
   assign bus.busy    = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed table, corner-case
// sequences and a randomized run against a transaction-level model.
module tb_dmem_arbiter;

   localparam int unsigned AW   = 6;
   localparam int unsigned DW   = 32;
   localparam int          MAXW = 4;

   logic clk;
   logic rst;

   dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   dmem_arbiter #(
      .ADDR_W   (AW),
      .DATA_W   (DW),
      .MAX_WAIT (MAXW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: combinational read, write on rising edge, plus a
   // backdoor load port used only while the arbiter is held in reset.
   logic [DW-1:0] mem [64];
   logic          tb_we;
   logic [AW-1:0] tb_waddr;
   logic [DW-1:0] tb_wdata;

   assign bus.mem_rdata = bus.mem_read ? mem[bus.mem_addr] : '0;

   always @(posedge clk) begin
      if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_wdata;
      else if (tb_we)    mem[tb_waddr]     <= tb_wdata;
   end

   int vectors;
   int miscompares;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      chk(name, 32'(act), 32'(exp));
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic load(input int a, input logic [DW-1:0] v);
      tb_we    = 1'b1;
      tb_waddr = AW'(a);
      tb_wdata = v;
      tick();
      tb_we    = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   // Drop all requests and let any granted access run out.
   task automatic settle();
      bus.i_req = 1'b0;
      bus.d_req = 1'b0;
      for (int n = 0; n < 4; n++) begin
         if (!bus.busy) break;
         tick();
      end
      chk1("settle_idle", bus.busy, 1'b0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk(tag, {26'd0, bus.i_ack, bus.d_ack, bus.mem_read, bus.mem_write, bus.busy, 1'b0}, 32'd0);
      chk({tag, "_addr"},  32'(bus.mem_addr), 32'd0);
      chk({tag, "_wdata"}, bus.mem_wdata, 32'd0);
      chk({tag, "_irdata"}, bus.i_rdata, 32'd0);
      chk({tag, "_drdata"}, bus.d_rdata, 32'd0);
   endtask

   typedef struct {
      logic          is_d;
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] exp_rdata;
   } vec_t;

   vec_t tbl [9];

   // One isolated access from IDLE; checks the ACCESS, DONE and following IDLE cycles.
   task automatic do_single(input vec_t v);
      if (v.is_d) begin
         bus.d_req = 1'b1; bus.d_we = v.we; bus.d_addr = v.addr; bus.d_wdata = v.wdata;
      end else begin
         bus.i_req = 1'b1; bus.i_addr = v.addr;
      end
      tick();
      chk1("acc_busy", bus.busy, 1'b1);
      chk1("acc_iack", bus.i_ack, 1'b0);
      chk1("acc_dack", bus.d_ack, 1'b0);
      chk1("acc_mwrite", bus.mem_write, v.is_d & v.we);
      chk1("acc_mread", bus.mem_read, !(v.is_d & v.we));
      chk("acc_maddr", 32'(bus.mem_addr), 32'(v.addr));
      tick();
      chk1("done_own_ack", v.is_d ? bus.d_ack : bus.i_ack, 1'b1);
      chk1("done_other_ack", v.is_d ? bus.i_ack : bus.d_ack, 1'b0);
      chk("done_rdata", v.is_d ? bus.d_rdata : bus.i_rdata, v.exp_rdata);
      chk1("done_mwrite", bus.mem_write, 1'b0);
      bus.i_req = 1'b0;
      bus.d_req = 1'b0;
      tick();
      chk1("idle_busy", bus.busy, 1'b0);
      chk1("idle_acks", bus.i_ack | bus.d_ack, 1'b0);
      chk1("idle_mwrite", bus.mem_write, 1'b0);
   endtask

   // Randomized-phase model state.
   logic [DW-1:0] shadow [64];
   int            rem;
   int            losses;
   logic          own_d;
   logic          g_we;
   logic [AW-1:0] g_addr;
   logic [DW-1:0] g_wdata;
   logic [DW-1:0] exp_ir, exp_dr;
   logic          i_pend, d_pend;

   initial begin
      int grants, last_ack, nacks;
      logic exp_iack, exp_dack, d_wins;

      vectors = 0; miscompares = 0;
      rst = 1'b1; tb_we = 1'b0; tb_waddr = '0; tb_wdata = '0;
      bus.i_req = 1'b0; bus.i_addr = '0;
      bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;

      @(negedge clk);
      for (int a = 0; a < 64; a++) load(a, 32'd0);
      load(0, 32'd17); load(1, 32'd9); load(2, 32'd25); load(3, 32'd30); load(4, 32'd12);
      rst = 1'b0;
      chk_all_zero("reset");
      tick();
      chk_all_zero("reset_idle");

      tbl[0] = '{1'b0, 1'b0, 6'd2,  32'd0,          32'd25};
      tbl[1] = '{1'b1, 1'b1, 6'd4,  32'd99,         32'd0};
      tbl[2] = '{1'b0, 1'b0, 6'd4,  32'd0,          32'd99};
      tbl[3] = '{1'b0, 1'b0, 6'd1,  32'd0,          32'd9};
      tbl[4] = '{1'b1, 1'b0, 6'd3,  32'd0,          32'd30};
      tbl[5] = '{1'b1, 1'b0, 6'd0,  32'd0,          32'd17};
      tbl[6] = '{1'b1, 1'b1, 6'd63, 32'hDEADBEEF,   32'd0};
      tbl[7] = '{1'b0, 1'b0, 6'd63, 32'd0,          32'hDEADBEEF};
      tbl[8] = '{1'b1, 1'b0, 6'd63, 32'd0,          32'hDEADBEEF};
      for (int k = 0; k < 9; k++) do_single(tbl[k]);

      // Requester drops req during ACCESS: the access still completes.
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 6'd3;
      tick();
      bus.d_req = 1'b0;
      tick();
      chk1("drop_dack", bus.d_ack, 1'b1);
      chk("drop_drdata", bus.d_rdata, 32'd30);
      tick();
      chk1("drop_idle", bus.busy, 1'b0);

      // Contention: D wins MAX_WAIT times, then I is forced through.
      do_reset();
      bus.i_req = 1'b1; bus.i_addr = 6'd2;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 6'd0;
      grants = 0;
      for (int cyc = 0; cyc < 80 && grants < 10; cyc++) begin
         tick();
         if (bus.i_ack && bus.d_ack) begin
            chk1("starve_both_acks", 1'b1, 1'b0);
         end else if (bus.i_ack || bus.d_ack) begin
            chk1("starve_winner_is_i", bus.i_ack, (grants % 5) == 4);
            if (bus.i_ack) chk("starve_irdata", bus.i_rdata, 32'd25);
            else           chk("starve_drdata", bus.d_rdata, 32'd17);
            grants++;
         end
      end
      chk("starve_grants", grants, 10);
      settle();

      // D alone, back-to-back: one ack every 3 cycles, busy low only in IDLE.
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 6'd3;
      last_ack = -1; nacks = 0;
      for (int cyc = 0; cyc < 30; cyc++) begin
         tick();
         chk1("dstream_iack", bus.i_ack, 1'b0);
         if (bus.d_ack) begin
            if (last_ack >= 0) chk("dstream_gap", cyc - last_ack, 3);
            chk("dstream_drdata", bus.d_rdata, 32'd30);
            last_ack = cyc;
            nacks++;
         end
         if (!bus.busy && last_ack >= 0) chk("dstream_idle_after_ack", cyc - 1, last_ack);
      end
      chk1("dstream_count", nacks >= 9, 1'b1);
      settle();

      // Reset during ACCESS of a write: write suppressed, no ack.
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 6'd1; bus.d_wdata = 32'd55;
      tick();
      chk1("rstw_access_mwrite", bus.mem_write, 1'b1);
      rst = 1'b1;
      bus.d_req = 1'b0;
      #1;
      chk1("rstw_gated_mwrite", bus.mem_write, 1'b0);
      tick();
      rst = 1'b0;
      chk_all_zero("rstw_after");
      for (int n = 0; n < 4; n++) begin
         tick();
         chk1("rstw_no_dack", bus.d_ack, 1'b0);
      end
      chk("rstw_mem1", mem[1], 32'd9);

      // Randomized run against the transaction-level model.
      rst = 1'b1;
      for (int a = 0; a < 64; a++) begin
         logic [DW-1:0] v;
         v = $urandom;
         shadow[a] = v;
         load(a, v);
      end
      rst = 1'b0;
      rem = 0; losses = 0; own_d = 1'b1; g_we = 1'b0; g_addr = '0; g_wdata = '0;
      exp_ir = '0; exp_dr = '0; i_pend = 1'b0; d_pend = 1'b0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         exp_iack = (rem == 1) && !own_d;
         exp_dack = (rem == 1) &&  own_d;
         chk1("rnd_iack", bus.i_ack, exp_iack);
         chk1("rnd_dack", bus.d_ack, exp_dack);
         chk1("rnd_busy", bus.busy, rem != 0);
         chk("rnd_irdata", bus.i_rdata, exp_ir);
         chk("rnd_drdata", bus.d_rdata, exp_dr);

         if (exp_iack) i_pend = 1'b0;
         if (exp_dack) d_pend = 1'b0;
         if ($urandom_range(0, 99) == 0) begin
            rst = 1'b1; i_pend = 1'b0; d_pend = 1'b0;
         end else begin
            rst = 1'b0;
            if (!i_pend && $urandom_range(0, 1) == 1) begin
               i_pend = 1'b1;
               bus.i_addr = AW'($urandom_range(0, 63));
            end
            if (!d_pend && $urandom_range(0, 1) == 1) begin
               d_pend = 1'b1;
               bus.d_addr  = AW'($urandom_range(0, 63));
               bus.d_we    = 1'($urandom_range(0, 1));
               bus.d_wdata = $urandom;
            end
         end
         bus.i_req = i_pend;
         bus.d_req = d_pend;

         @(posedge clk);
         if (rst) begin
            rem = 0; losses = 0; exp_ir = '0; exp_dr = '0;
         end else if (rem == 2) begin
            rem = 1;
            if (!own_d) begin
               exp_ir = shadow[g_addr];
            end else if (g_we) begin
               shadow[g_addr] = g_wdata;
               exp_dr = '0;
            end else begin
               exp_dr = shadow[g_addr];
            end
         end else if (rem == 1) begin
            rem = 0;
         end else if (bus.i_req || bus.d_req) begin
            d_wins = bus.d_req && !(bus.i_req && losses == MAXW);
            if (d_wins) begin
               own_d = 1'b1; g_we = bus.d_we; g_addr = bus.d_addr; g_wdata = bus.d_wdata;
               if (bus.i_req) losses = (losses < MAXW) ? losses + 1 : MAXW;
            end else begin
               own_d = 1'b0; g_we = 1'b0; g_addr = bus.i_addr; g_wdata = '0;
               losses = 0;
            end
            rem = 2;
         end
         @(negedge clk);
      end
      rst = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares one single-ported data memory (combinational read, write on rising clk, word-addressed) between two requesters.
- Requester I is the instruction-fetch port and is read-only. Requester D is the load/store port and can read or write.
- Sits between the pipeline's IF/MEM stages and the memory. Stalls the losing stage via held req / absent ack.
- D has fixed priority, with a starvation guard for I.

Parameters:
- ADDR_W, 6, word-address width (64-entry memory).
- DATA_W, 32, data word width.
- MAX_WAIT, 4, number of lost arbitrations after which I is forced to win; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_req  in  1  I access request; held until i_ack.
- i_addr  in  ADDR_W  I word address; stable while i_req.
- i_ack  out  1  one-cycle pulse, I access complete.
- i_rdata  out  DATA_W  I read data; valid in the i_ack cycle, held until the next I completion.
- d_req  in  1  D access request; held until d_ack.
- d_we  in  1  D is a write (1) or read (0); stable while d_req.
- d_addr  in  ADDR_W  D word address.
- d_wdata  in  DATA_W  D write data.
- d_ack  out  1  one-cycle pulse, D access complete.
- d_rdata  out  DATA_W  D read data (zero-held on writes); valid in the d_ack cycle.
- mem_read  out  1  memory read enable.
- mem_write  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data (combinational from mem_addr/mem_read).
- busy  out  1  high in ACCESS or DONE.

Behaviour:
- Reset values: state IDLE; i_ack, d_ack, mem_read, mem_write, busy = 0; mem_addr, mem_wdata, i_rdata, d_rdata = 0; wait_cnt = 0; owner = D.

FSM: IDLE -> ACCESS -> DONE -> IDLE.
- IDLE, no req: stay.
- IDLE, any req: choose winner, latch owner, addr, we and wdata into registers, go to ACCESS.

Arbitration (IDLE only):
- d_req only: D wins.
- i_req only: I wins.
- Both requesting: D wins unless wait_cnt == MAX_WAIT, in which case I wins.

Wait counter:
- Increments (saturating at MAX_WAIT) whenever I loses with i_req high.
- Clears whenever I wins.

ACCESS (exactly 1 cycle):
- mem_addr and mem_wdata come from the latched registers.
- mem_read = !latched_we; mem_write = latched_we & !rst.
- At the end-of-cycle edge, mem_rdata is captured into the owner's rdata register; D write captures 0.
- Go to DONE.

DONE (1 cycle):
- The owner's ack = 1; mem_read = mem_write = 0.
- No arbitration in this cycle.
- The requester drops or changes req at the end of DONE.
- Go to IDLE.

Timing and throughput:
- Latency: req seen at edge k -> ACCESS cycle k+1 -> ack high in cycle k+2.
- Back-to-back: 1 access per 3 cycles.
- The non-owner's req is ignored until the next IDLE; its ack stays 0.
- Never both acks in the same cycle.

Boundary conditions:
- rst in any state: returns to IDLE next edge and the in-flight access is abandoned (no ack). A write in ACCESS is suppressed because mem_write is gated by rst.
- Requester dropping req mid-access (protocol violation): the access still completes and ack is still pulsed.
- Address wrap: none; ADDR_W bits are passed straight through.
- No same-cycle forwarding: a D write followed by an I read of the same address returns the new value because the accesses are serialised.

Decomposition:
- Shared package dmem_arb_pkg:
  - state enum {IDLE, ACCESS, DONE};
  - owner constants OWN_I = 1'b0, OWN_D = 1'b1;
  - default ADDR_W / DATA_W constants.
- One sub-module, arb_wait_counter: saturating counter with inc, clr and sat outputs, parameterised by MAX_WAIT.
- All other logic stays in dmem_arbiter.

Test Plan:
- Memory preloaded {17, 9, 25, 30, 12}. I single read, i_addr = 2 -> i_ack exactly 2 cycles after the req-sampling edge, i_rdata = 25, d_ack stays 0.
- D write d_addr = 4, d_wdata = 99, then I read addr 4 -> d_ack, then i_ack with i_rdata = 99. mem_write high for exactly one cycle.
- i_req and d_req held simultaneously, D reading addr 0 continuously -> D wins 4 times (d_rdata = 17), 5th grant goes to I (i_rdata = i_addr's value). Pattern repeats; wait_cnt clears after the I grant.
- rst asserted during ACCESS of D write addr 1, data 55 -> no d_ack, mem_write low, mem[1] still 9. All outputs 0 the cycle after reset.
- d_req only, held continuously (addr 3) -> d_ack every 3rd cycle, d_rdata = 30, busy low only in IDLE cycles.
- i_req only, addr 1 -> i_rdata = 9. wait_cnt stays 0 and never increments without contention.
